ifetch_prefetch: RTL and testbench
==================================

# ifetch_prefetch

Instruction fetch stage with a small prefetch queue, sitting directly upstream of the single-cycle RV32 core's decode/execute path. It generates sequential word addresses into the synchronous instruction memory, buffers returned instructions with their PCs, and presents them to the core over a valid/ready handshake. It also accepts branch/jump redirects from the core, flushing queued and in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, prefetch queue entries (power of two, 2..16)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request this cycle
- imem_req_addr  out  32  byte address of requested word (bits [1:0] always 0)
- imem_rsp_valid  in  1  read data valid (exactly 1 cycle after request)
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  core requests PC change (taken branch/jump)
- redirect_pc  in  32  new fetch target
- out_valid  out  1  instruction available to core
- out_ready  in  1  core accepts instruction
- out_instr  out  32  instruction word
- out_pc  out  32  PC of out_instr
- perf_fetch_cnt  out  32  (only with IFETCH_PERF_EN) instructions delivered
- perf_flush_cnt  out  32  (only with IFETCH_PERF_EN) redirects taken

## Operation
- fetch_pc register, reset to RESET_PC; advances by 4 per issued request; wraps 32'hFFFF_FFFC -> 32'h0.
- Credit rule: issue request iff (occupancy + inflight) < DEPTH and no redirect this cycle; inflight is 0 or 1.
- Response pushed into queue with its PC (captured PC of the request, held in a 1-entry inflight register).
- out_valid = queue non-empty AND NOT redirect_valid; out_instr/out_pc = head entry; pop on out_valid && out_ready.
- Redirect (redirect_valid=1): queue cleared, inflight response marked dead (dropped on arrival next cycle), fetch_pc <= {redirect_pc[31:2],2'b00}; no request that cycle; request to redirect target issued next cycle.
- Redirect wins over simultaneous push, pop, and request.
- Push and pop in the same cycle when full: both allowed (occupancy unchanged).
- imem_rsp_valid arriving with no live inflight is ignored.

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, queue empty, inflight=0, perf counters 0.
- First request the cycle after reset deasserts; first out_valid 2 cycles after reset deasserts (request, response, push visible next edge).
- Steady state with out_ready=1: one instruction per cycle after initial 2-cycle fill.
- Redirect penalty: target instruction on out_valid 3 cycles after the redirect cycle (cycle+1 request, +2 response/push, +3 visible).
- Reset mid-operation: all state returns to reset values on the next edge; any response in flight is dropped.

## Configuration
- IFETCH_PERF_EN defined: perf_fetch_cnt increments on each handshake, perf_flush_cnt on each redirect cycle; both 32-bit, wrap at 2^32, cleared on reset.
- Undefined: both ports and counters absent; no other behaviour change.

## Structure
- Shared package riscv_pkg: XLEN=32, INSTR_W=32, PC_STEP=4, NOP encoding 32'h0000_0013 (used by core on empty queue).
- One sub-module: ifetch_fifo (DEPTH x 64-bit {pc,instr} sync FIFO, flush input, count output); fetch/credit/redirect logic stays in ifetch_prefetch.

## Test plan
- Reset, RESET_PC=0, memory holds addr>>2 as data, out_ready=1 -> out_pc 0,4,8,12 on consecutive cycles from cycle 2, out_instr 0,1,2,3.
- out_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, imem_req_valid then 0; release -> 4 queued then sequential continue, no gap/duplicate.
- Redirect to 32'h100 while queue holds 3 entries and a response is in flight -> none of the old entries appear; out_pc=32'h100 exactly 3 cycles after redirect.
- Redirect to 32'h203 -> fetch at 32'h200; redirect asserted same cycle as out_ready with valid head -> out_valid low, no handshake counted.
- RESET_PC=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With IFETCH_PERF_EN: 20 handshakes, 2 redirects -> perf_fetch_cnt=20, perf_flush_cnt=2; reset asserted mid-stream -> both 0 and out_valid=0 next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: widths, the PC step, the NOP encoding and the
// {pc, instr} entry carried through the prefetch queue.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instruction fetches are always word aligned; low address bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch queue of {pc, instr} entries with a single-cycle flush
// and an occupancy count used by the fetch credit logic.
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign count     = count_q;
    assign head_data = mem[rd_ptr];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Sequential instruction fetch with a credit-limited prefetch queue and redirect flush.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module ifetch_prefetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic            inflight_valid;
    logic [XLEN-1:0] inflight_pc;
    logic [AW+1:0]   credit_used;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic [AW:0]     fifo_count;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Queued entries plus the outstanding fetch must never exceed the queue size.
    assign credit_used = {1'b0, fifo_count} + (AW+2)'(inflight_valid);
    assign req_fire    = !reset && !redirect_valid && (credit_used < (AW+2)'(DEPTH));

    assign imem_req_valid = req_fire;
    assign imem_req_addr  = fetch_pc;

    // A response with no live request behind it is stale and is discarded.
    assign push       = imem_rsp_valid && inflight_valid && !redirect_valid;
    assign push_entry = '{pc: inflight_pc, instr: imem_rsp_data};

    assign out_valid = !fifo_empty && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_instr = fifo_empty ? '0 : head.instr;
    assign out_pc    = fifo_empty ? '0 : head.pc;

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // No request is issued in a redirect cycle, so the in-flight slot empties and
    // the response already on its way back is dropped by the push gating.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc       <= RESET_PC;
            inflight_valid <= 1'b0;
            inflight_pc    <= '0;
        end else begin
            inflight_valid <= req_fire;
            if (req_fire) inflight_pc <= fetch_pc;
            if (redirect_valid) fetch_pc <= align_word(redirect_pc);
            else if (req_fire)  fetch_pc <= fetch_pc + PC_STEP;
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop)            perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`endif

    // fifo_full is only a cross-check of the credit rule and needs no action here.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Randomized bench for ifetch_prefetch: delivered instructions are compared with a
// program-order PC model, plus fill, credit, redirect-latency and wrap checks.
module tb_ifetch_prefetch;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        out_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        imem_req_valid, out_valid;
    logic [31:0] imem_req_addr, out_instr, out_pc;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;

    logic        w_req_valid, w_out_valid;
    logic [31:0] w_req_addr, w_out_instr, w_out_pc;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = '0;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_flush_cnt, w_perf_fetch, w_perf_flush;
`endif

    ifetch_prefetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    ifetch_prefetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_instr(w_out_instr), .out_pc(w_out_pc)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(w_perf_fetch), .perf_flush_cnt(w_perf_flush)
`endif
    );

    // Instruction memories: one-cycle read latency, each word holds its address >> 2.
    always @(posedge clk) begin
        imem_rsp_valid <= imem_req_valid;
        imem_rsp_data  <= imem_req_addr >> 2;
        w_rsp_valid    <= w_req_valid;
        w_rsp_data     <= w_req_addr >> 2;
    end

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] model_pc = '0;
    logic [31:0] redir_target = '0;
    int          redir_age = -1;
    int          since_rst = 0;
    int          hs_total = 0;
    int          redir_total = 0;
    int          req_cnt = 0;
    logic        last_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock cycle: drive inputs, observe at the falling edge, update the model.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        last_valid = out_valid;
        if (!reset) begin
            if (redir_age >= 0) redir_age++;
            if (imem_req_valid) begin
                req_cnt++;
                check("req_align", imem_req_addr[1:0], 0);
            end
            if (rv) check("valid_in_redirect", out_valid, 0);
            if (!rv && (redir_age == 1 || redir_age == 2)) check("bubble_after_redirect", out_valid, 0);
            if (!rv && redir_age == 3) begin
                check("redirect_latency", out_valid, 1);
                check("redirect_target", out_pc, redir_target);
            end
            if (redir_age > 3) redir_age = -1;
            if (since_rst == 0) begin
                check("first_req_valid", imem_req_valid, 1);
                check("first_req_addr", imem_req_addr, 32'h0);
            end
            if (since_rst < 2) check("fill_gap", out_valid, 0);
            if (since_rst == 2 && !rv) check("first_valid", out_valid, 1);
            if (since_rst >= 2 && since_rst <= 4) begin
                check("wrap_valid", w_out_valid, 1);
                check("wrap_pc", w_out_pc, 32'hFFFF_FFF8 + 32'(4 * (since_rst - 2)));
                check("wrap_instr", w_out_instr, (32'hFFFF_FFF8 + 32'(4 * (since_rst - 2))) >> 2);
            end
            if (out_valid && out_ready) begin
                check("out_pc", out_pc, model_pc);
                check("out_instr", out_instr, model_pc >> 2);
                model_pc = model_pc + 32'd4;
                hs_total++;
            end
            if (rv) begin
                model_pc     = {rpc[31:2], 2'b00};
                redir_target = model_pc;
                redir_age    = 0;
                redir_total++;
            end
            since_rst++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf();
`ifdef IFETCH_PERF_EN
        check("perf_fetch_cnt", perf_fetch_cnt, hs_total);
        check("perf_flush_cnt", perf_flush_cnt, redir_total);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_wrap_addr", w_req_addr, 32'hFFFF_FFF8);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_pc", out_pc, 0);
        model_pc    = 32'h0;
        hs_total    = 0;
        redir_total = 0;
        redir_age   = -1;
        check_perf();
        cycle(1'b0, 1'b0, 32'h0);
        reset     = 1'b0;
        since_rst = 0;
        req_cnt   = 0;
    endtask

    initial begin
        // Streaming from reset with the core always ready.
        do_reset();
        repeat (8) cycle(1'b1, 1'b0, 32'h0);
        check("stream_hs", hs_total, 6);

        // Core stalled: only DEPTH requests may be outstanding, then a gapless drain.
        do_reset();
        repeat (10) cycle(1'b0, 1'b0, 32'h0);
        check("credit_requests", req_cnt, DEPTH);
        check("credit_stall", imem_req_valid, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            check("release_no_gap", last_valid, 1);
        end
        check("release_hs", hs_total, 10);

        // Redirect with three queued entries and one response in flight.
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0100);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        // Unaligned target while the core is taking a valid head.
        repeat (3) cycle(1'b1, 1'b0, 32'h0);
        begin
            int hs_before;
            hs_before = hs_total;
            cycle(1'b1, 1'b1, 32'h0000_0203);
            check("no_hs_on_redirect", hs_total, hs_before);
        end
        repeat (6) cycle(1'b1, 1'b0, 32'h0);
        check_perf();

        // Random backpressure and redirects.
        for (int i = 0; i < 400; i++) begin
            logic        rdy, rv;
            logic [31:0] tgt;
            rdy = ($urandom_range(3) != 0);
            rv  = (since_rst >= 3) && ($urandom_range(15) == 0);
            tgt = $urandom;
            cycle(rdy, rv, tgt);
        end
        check_perf();

        // Reset in the middle of a stream, then restart.
        repeat (5) cycle(1'b1, 1'b0, 32'h0);
        do_reset();
        repeat (8) cycle(1'b1, 1'b0, 32'h0);
        check_perf();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
